// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the 1-bit serial link: transmitter state encoding and the
// default sync pattern that also parameterises the receive-side 110 detector.
package serial_frame_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } tx_state_e;

  localparam int                        SYNC_W_DEFAULT   = 3;
  localparam logic [SYNC_W_DEFAULT-1:0] SYNC_PAT_DEFAULT = 3'b110;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Payload valid/ready handshake between an upstream producer and the serial transmitter.
interface serial_frame_tx_if #(
  parameter int PAYLOAD_W = 8
);
  logic                 in_valid;
  logic [PAYLOAD_W-1:0] in_data;
  logic                 in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: sync pattern, MSB-first payload, then idle gap bits.
// Every output is registered from the next-state values, so the line changes on the accept edge.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int                PAYLOAD_W  = 8,
  parameter int                SYNC_W     = SYNC_W_DEFAULT,
  parameter logic [SYNC_W-1:0] SYNC_PAT   = SYNC_PAT_DEFAULT,
  parameter int                GAP_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_frame_tx_if.slave        payload,
  output logic                    out_bit,
  output logic                    out_en,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int CNT_MAX = max3(SYNC_W, PAYLOAD_W, GAP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  tx_state_e            state_reg,      state_next;
  logic [CNT_W-1:0]     cnt_reg,        cnt_next;
  logic [PAYLOAD_W-1:0] shift_reg,      shift_next;
  logic                 out_bit_reg,    out_bit_next;
  logic                 out_en_reg,     out_en_next;
  logic                 frame_done_reg, frame_done_next;
  logic                 busy_reg,       busy_next;
  logic                 in_ready_reg,   in_ready_next;
  logic [SYNC_W-1:0]    sync_word;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      out_bit_reg    <= 1'b0;
      out_en_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
      in_ready_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      shift_reg      <= shift_next;
      out_bit_reg    <= out_bit_next;
      out_en_reg     <= out_en_next;
      frame_done_reg <= frame_done_next;
      busy_reg       <= busy_next;
      in_ready_reg   <= in_ready_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    shift_next      = shift_reg;
    sync_word       = '0;
    out_bit_next    = 1'b0;
    out_en_next     = 1'b0;
    frame_done_next = 1'b0;
    busy_next       = 1'b0;
    in_ready_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (payload.in_valid && in_ready_reg) begin
          state_next = SYNC;
          cnt_next   = '0;
          shift_next = payload.in_data;
        end
      end
      SYNC: begin
        if (cnt_reg == SYNC_LAST) begin
          state_next = DATA;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      DATA: begin
        // The payload MSB is always the bit on the line; shift only while staying in DATA.
        if (cnt_reg == DATA_LAST) begin
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + CNT_ONE;
          shift_next = shift_reg << 1;
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    sync_word       = SYNC_PAT << cnt_next;
    out_en_next     = (state_next == SYNC) || (state_next == DATA);
    busy_next       = (state_next != IDLE);
    in_ready_next   = (state_next == IDLE);
    frame_done_next = (state_next == DATA) && (cnt_next == DATA_LAST);
    if (state_next == SYNC) begin
      out_bit_next = sync_word[SYNC_W-1];
    end else if (state_next == DATA) begin
      out_bit_next = shift_next[PAYLOAD_W-1];
    end
  end

  assign out_bit          = out_bit_reg;
  assign out_en           = out_en_reg;
  assign frame_done       = frame_done_reg;
  assign busy             = busy_reg;
  assign payload.in_ready = in_ready_reg;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomised scoreboard bench for serial_frame_tx with a loopback 110 detector on the line.
module tb_serial_frame_tx;

  localparam int         PW   = 8;
  localparam int         SW   = 3;
  localparam int         GC   = 2;
  localparam logic [2:0] SPAT = 3'b110;
  localparam int         LEN  = SW + PW + GC;
  localparam int         EN_LAST = SW + PW;

  typedef struct packed {
    logic b;
    logic last;
  } exp_bit_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic out_bit, out_en, frame_done, busy;

  serial_frame_tx_if #(.PAYLOAD_W(PW)) ifc ();

  serial_frame_tx #(
    .PAYLOAD_W (PW),
    .SYNC_W    (SW),
    .SYNC_PAT  (SPAT),
    .GAP_CYCLES(GC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .payload   (ifc),
    .out_bit   (out_bit),
    .out_en    (out_en),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model state: cycle index within the current frame (0 = idle)
  exp_bit_t sb_q[$];
  int       cyc       = 0;
  bit       m_ready   = 1'b0;
  int       exp_det   = 0;
  int       n_checks  = 0;
  int       n_pass    = 0;
  bit       timed_out = 1'b0;

  function automatic int count_110(input logic [SW+PW:0] s);
    int c;
    c = 0;
    for (int i = SW + PW; i >= 2; i--) begin
      if (s[i] && s[i-1] && !s[i-2]) c++;
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Model: a frame is sync + payload + gap; ready returns once the frame has fully elapsed
  initial begin
    logic [SW+PW:0] s;
    exp_bit_t       e;
    forever begin
      @(posedge clk);
      if (!rst) begin
        cyc     = 0;
        m_ready = 1'b0;
        sb_q.delete();
      end else if (cyc == 0 && m_ready && ifc.in_valid) begin
        s = {SPAT, ifc.in_data, 1'b0};
        for (int i = 0; i < SW + PW; i++) begin
          e.b    = s[SW+PW-i];
          e.last = (i == SW + PW - 1);
          sb_q.push_back(e);
        end
        exp_det = count_110(s);
        cyc     = 1;
        m_ready = 1'b0;
        $display("accept data=%02h expected_detections=%0d t=%0t", ifc.in_data, exp_det, $time);
      end else if (cyc != 0) begin
        if (cyc == LEN) begin
          cyc     = 0;
          m_ready = 1'b1;
        end else begin
          cyc++;
        end
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Monitor: per-cycle control checks, bit scoreboard on out_en, loopback detector counts
  initial begin
    exp_bit_t   e;
    int         det_cnt  = 0;
    int         first_det = 0;
    bit         det_pend = 1'b0;
    bit         det_now;
    logic [1:0] h        = 2'b00;
    bit         in_frame = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      check("in_ready", ifc.in_ready, m_ready);
      check("busy", busy, cyc != 0);
      check("out_en", out_en, (cyc >= 1) && (cyc <= EN_LAST));
      if (out_en) begin
        check("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("out_bit", out_bit, e.b);
          check("frame_done", frame_done, e.last);
        end
      end else begin
        check("idle_bit", out_bit, 0);
        check("idle_done", frame_done, 0);
      end

      det_now  = det_pend;
      det_pend = (h == 2'b11) && !out_bit;
      h        = {h[0], out_bit};
      if (cyc == 1) begin
        in_frame  = 1'b1;
        det_cnt   = 0;
        first_det = 0;
      end
      if (in_frame && det_now) begin
        det_cnt++;
        if (first_det == 0) first_det = cyc;
      end
      if (in_frame && cyc == 0) begin
        in_frame = 1'b0;
        if (m_ready) begin
          check("det_count", det_cnt, exp_det);
          check("det_first_cycle", first_det, SW + 1);
          check("sb_drained", sb_q.size(), 0);
          $display("frame end detections=%0d expected=%0d t=%0t", det_cnt, exp_det, $time);
        end
      end
      check("watchdog", timed_out, 0);
    end
  end

  task automatic wait_accept(input bit hold);
    int t;
    t = 0;
    while (!ifc.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      $display("FAIL accept_timeout: in_ready stayed %0b, required 1 within 100 cycles", ifc.in_ready);
      timed_out = 1'b1;
    end
    @(negedge clk);
    if (!hold) ifc.in_valid = 1'b0;
  endtask

  task automatic send(input logic [PW-1:0] d, input bit hold);
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    wait_accept(hold);
  endtask

  task automatic wait_cyc(input int n);
    int t;
    t = 0;
    while (cyc != n && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      $display("FAIL cycle_timeout: frame cycle %0d, required %0d", cyc, n);
      timed_out = 1'b1;
    end
  endtask

  initial begin
    int pick;
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'hA5;
    rst          = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_accept(1'b0);

    send(8'hFF, 1'b1);
    send(8'h00, 1'b0);

    send(8'h5B, 1'b0);
    wait_cyc(SW + 4);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    send(8'h00, 1'b0);
    send(8'hD8, 1'b0);

    send(8'h96, 1'b0);
    wait_cyc(SW + 2);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h3C;
    @(negedge clk);
    ifc.in_valid = 1'b0;

    repeat (40) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom), 1'($urandom_range(0, 1)));
      pick = $urandom_range(0, 9);
      if (pick < 3) begin
        wait_cyc($urandom_range(2, LEN));
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'($urandom);
        @(negedge clk);
        ifc.in_valid = 1'b0;
      end else if (pick == 3) begin
        wait_cyc($urandom_range(2, LEN));
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    ifc.in_valid = 1'b0;
    repeat (LEN + 4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
